arcade_input_conditioner: RTL

- Sits between the raw player-input merge (keyboard/joystick OR) and the core's in0/in1 buses. Receives active-high raw buttons.
- Debounces every button.
- Converts coin presses into frame-locked coin pulses of fixed length. Presses are queued so that rapid inserts are not lost.
- Outputs stay active-high; the top level keeps applying the per-game XOR/inversion.

---
 rtl/arcade_input_conditioner.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/arcade_input_conditioner.sv
// Player-input conditioner: per-bit debounce of buttons and coin, plus a queued,
// frame-locked coin pulse shaper driven by the rising edge of vblank.
module arcade_input_conditioner #(
  parameter int NBTN        = 8,
  parameter int DEB_TICKS   = 16,
  parameter int COIN_FRAMES = 4,
  parameter int GAP_FRAMES  = 4,
  parameter int QDEPTH      = 7
) (
  input  logic            clk_sys,
  input  logic            reset_n,
  input  logic            ce,
  input  logic            vblank,
  input  logic [NBTN-1:0] btn_raw,
  input  logic            coin_raw,
  output logic [NBTN-1:0] btn_out,
  output logic            coin_out,
  output logic [7:0]      coin_pending,
  output logic            coin_ovf
);

  localparam int NB   = NBTN + 1;
  localparam int CW   = $clog2(DEB_TICKS + 1);
  localparam int FMAX = (COIN_FRAMES > GAP_FRAMES) ? COIN_FRAMES : GAP_FRAMES;
  localparam int FW   = $clog2(FMAX + 1);

  localparam logic [CW-1:0] CNT_LAST   = CW'(DEB_TICKS - 1);
  localparam logic [FW-1:0] COIN_LAST  = FW'(COIN_FRAMES - 1);
  localparam logic [FW-1:0] GAP_LAST   = FW'(GAP_FRAMES - 1);
  localparam logic [7:0]    QDEPTH_V   = 8'(QDEPTH);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PULSE = 2'd1;
  localparam logic [1:0] ST_GAP   = 2'd2;

  logic [NB-1:0] raw_s;
  logic [CW-1:0] deb_cnt_q [NB];
  logic [CW-1:0] deb_cnt_d [NB];
  logic [NB-1:0] stable_q, stable_d;
  logic          coin_prev_q, coin_prev_d;
  logic          vblank_prev_q, vblank_prev_d;
  logic [1:0]    state_q, state_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          coin_out_q, coin_out_d;
  logic [7:0]    coin_pending_q, coin_pending_d;
  logic          coin_ovf_q, coin_ovf_d;
  logic          tick_s, coin_evt_s, deq_s;

  // Bit NBTN of the debounce bank is the coin button.
  assign raw_s       = {coin_raw, btn_raw};
  assign tick_s      = vblank & ~vblank_prev_q;
  assign coin_evt_s  = stable_q[NBTN] & ~coin_prev_q;
  assign deq_s       = (state_q == ST_IDLE) & tick_s & (coin_pending_q != 8'd0);

  assign vblank_prev_d = vblank;
  assign coin_prev_d   = stable_q[NBTN];

  // Debounce: a level is accepted after DEB_TICKS consecutive mismatching ce samples.
  always_comb begin
    stable_d = stable_q;
    for (int i = 0; i < NB; i++) begin
      deb_cnt_d[i] = deb_cnt_q[i];
      if (!ce) begin
        deb_cnt_d[i] = deb_cnt_q[i];
      end else if (raw_s[i] == stable_q[i]) begin
        deb_cnt_d[i] = {CW{1'b0}};
      end else if (deb_cnt_q[i] == CNT_LAST) begin
        stable_d[i]  = raw_s[i];
        deb_cnt_d[i] = {CW{1'b0}};
      end else begin
        deb_cnt_d[i] = deb_cnt_q[i] + CW'(1);
      end
    end
  end

  // Coin queue: an enqueue and a dequeue in the same cycle cancel, so no overflow then.
  always_comb begin
    coin_pending_d = coin_pending_q;
    coin_ovf_d     = 1'b0;
    if (coin_evt_s && deq_s) begin
      coin_pending_d = coin_pending_q;
    end else if (coin_evt_s) begin
      if (coin_pending_q < QDEPTH_V) begin
        coin_pending_d = coin_pending_q + 8'd1;
      end else begin
        coin_ovf_d = 1'b1;
      end
    end else if (deq_s) begin
      coin_pending_d = coin_pending_q - 8'd1;
    end else begin
      coin_pending_d = coin_pending_q;
    end
  end

  // Pulse shaper: COIN_FRAMES ticks high, then GAP_FRAMES ticks before accepting a new start.
  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    coin_out_d = coin_out_q;
    case (state_q)
      ST_IDLE: begin
        if (deq_s) begin
          state_d    = ST_PULSE;
          coin_out_d = 1'b1;
          fcnt_d     = {FW{1'b0}};
        end else begin
          coin_out_d = 1'b0;
        end
      end
      ST_PULSE: begin
        if (!tick_s) begin
          fcnt_d = fcnt_q;
        end else if (fcnt_q == COIN_LAST) begin
          state_d    = ST_GAP;
          coin_out_d = 1'b0;
          fcnt_d     = {FW{1'b0}};
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      ST_GAP: begin
        if (!tick_s) begin
          fcnt_d = fcnt_q;
        end else if (fcnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
          fcnt_d  = {FW{1'b0}};
        end else begin
          fcnt_d = fcnt_q + FW'(1);
        end
      end
      default: begin
        state_d    = ST_IDLE;
        coin_out_d = 1'b0;
        fcnt_d     = {FW{1'b0}};
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      for (int i = 0; i < NB; i++) begin
        deb_cnt_q[i] <= {CW{1'b0}};
      end
      stable_q       <= {NB{1'b0}};
      coin_prev_q    <= 1'b0;
      vblank_prev_q  <= 1'b0;
      state_q        <= ST_IDLE;
      fcnt_q         <= {FW{1'b0}};
      coin_out_q     <= 1'b0;
      coin_pending_q <= 8'd0;
      coin_ovf_q     <= 1'b0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        deb_cnt_q[i] <= deb_cnt_d[i];
      end
      stable_q       <= stable_d;
      coin_prev_q    <= coin_prev_d;
      vblank_prev_q  <= vblank_prev_d;
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      coin_out_q     <= coin_out_d;
      coin_pending_q <= coin_pending_d;
      coin_ovf_q     <= coin_ovf_d;
    end
  end

  assign btn_out      = stable_q[NBTN-1:0];
  assign coin_out     = coin_out_q;
  assign coin_pending = coin_pending_q;
  assign coin_ovf     = coin_ovf_q;

endmodule
